enc_rr_arbiter: RTL and testbench

ENC_RR_ARBITER -- requirements
Module: enc_rr_arbiter

---
 rtl/enc_rr_arbiter.sv | 108 ++++++++++
 tb/tb_enc_rr_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/enc_rr_arbiter.sv
// Eight-requester round-robin arbiter. It issues a registered one-hot grant with
// a binary index on x/y/z and revokes the grant on done, request drop or hold expiry.
module enc_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] last_q, last_d;
  logic       timeout_q, timeout_d;

  logic [2:0] win_idx;
  logic       expired, released;

  // Walk from the farthest offset down, so the nearest set bit after last_q wins.
  // Offset 8 wraps to last_q itself and has the lowest priority.
  always_comb begin
    win_idx = last_q;
    for (int i = 8; i >= 1; i--) begin
      if (req[last_q + 3'(i)]) win_idx = last_q + 3'(i);
    end
  end

  assign expired  = (cnt_q == 8'(MAX_HOLD));
  assign released = done | ~req[idx_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = 8'b1 << win_idx;
          idx_d   = win_idx;
          last_d  = win_idx;
          cnt_d   = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (released || expired) begin
          // A timeout is flagged only when expiry alone ended the grant.
          timeout_d = expired & ~released;
          gnt_d     = '0;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      last_q    <= 3'd7;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign {x, y, z} = idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Directed scoreboard checks of enc_rr_arbiter, then a random phase that checks
// one-hot, index, valid, hold-length and starvation invariants.
module tb_enc_rr_arbiter;
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic       gnt_valid, x, y, z, timeout;

  enc_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .x(x), .y(y), .z(z), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;

  function automatic logic [2:0] enc(input logic [7:0] g);
    enc = '0;
    for (int i = 0; i < 8; i++) if (g[i]) enc = 3'(i);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge.
  task automatic step(input logic [7:0] r, input logic d, input logic [7:0] eg,
                      input logic et, input string tag);
    exp_t e;
    req  = r;
    done = d;
    e.gnt = eg;
    e.to  = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".gnt"}, gnt, e.gnt);
    chk({tag, ".xyz"}, {5'd0, x, y, z}, {5'd0, enc(e.gnt)});
    chk({tag, ".vld"}, {7'd0, gnt_valid}, {7'd0, |e.gnt});
    chk({tag, ".to"}, {7'd0, timeout}, {7'd0, e.to});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".gnt"}, gnt, 8'h00);
    chk({tag, ".xyz"}, {5'd0, x, y, z}, 8'h00);
    chk({tag, ".vld"}, {7'd0, gnt_valid}, 8'h00);
    chk({tag, ".to"}, {7'd0, timeout}, 8'h00);
  endtask

  logic [7:0] prev_req, prev_gnt;
  int         hold, starve[8];

  initial begin
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    #10 rst_n = 1'b1;

    // D0 and D7 both requesting: D0 first after reset, then D7.
    step(8'h81, 0, 8'h01, 0, "two_first");
    step(8'h81, 1, 8'h00, 0, "two_done");
    step(8'h81, 0, 8'h00, 0, "two_gap");
    step(8'h81, 0, 8'h80, 0, "two_second");
    step(8'h00, 0, 8'h00, 0, "two_drop");
    step(8'h00, 0, 8'h00, 0, "two_idle");

    // Full rotation with done on the third grant cycle, wrapping back to D0.
    for (int k = 0; k < 9; k++) begin
      logic [7:0] g;
      g = 8'h01 << (k % 8);
      step(8'hFF, 0, g, 0, "rot_c1");
      step(8'hFF, 0, g, 0, "rot_c2");
      step(8'hFF, 0, g, 0, "rot_c3");
      step(8'hFF, 1, 8'h00, 0, "rot_gap");
      step(8'hFF, 0, 8'h00, 0, "rot_idle");
    end
    step(8'h00, 0, 8'h00, 0, "rot_end");

    // Lone D5 holds until expiry, pulses timeout, then is re-granted.
    for (int k = 0; k < MAX_HOLD; k++) step(8'h20, 0, 8'h20, 0, "exp_hold");
    step(8'h20, 0, 8'h00, 1, "exp_timeout");
    step(8'h20, 0, 8'h00, 0, "exp_idle");
    step(8'h20, 0, 8'h20, 0, "exp_regrant");
    step(8'h00, 0, 8'h00, 0, "exp_drop");
    step(8'h00, 0, 8'h00, 0, "exp_end");

    // done coinciding with expiry is an ordinary release.
    for (int k = 0; k < MAX_HOLD; k++) step(8'h20, 0, 8'h20, 0, "dexp_hold");
    step(8'h20, 1, 8'h00, 0, "dexp_release");
    step(8'h00, 0, 8'h00, 0, "dexp_end");

    // Holder D2 drops its request while D6 waits.
    step(8'h04, 0, 8'h04, 0, "drop_d2");
    step(8'h44, 0, 8'h04, 0, "drop_hold");
    step(8'h40, 0, 8'h00, 0, "drop_gap");
    step(8'h40, 0, 8'h00, 0, "drop_idle");
    step(8'h40, 0, 8'h40, 0, "drop_d6");
    step(8'h00, 0, 8'h00, 0, "drop_rel");
    step(8'h00, 0, 8'h00, 0, "drop_end");

    // done outside GRANT has no effect.
    step(8'h00, 1, 8'h00, 0, "idone_idle");
    step(8'h08, 1, 8'h08, 0, "idone_d3");
    step(8'h08, 0, 8'h08, 0, "idone_hold");
    step(8'h00, 0, 8'h00, 0, "idone_rel");
    step(8'h00, 0, 8'h00, 0, "idone_end");

    // Asynchronous reset in the middle of D4's grant.
    step(8'h10, 0, 8'h10, 0, "rst_d4");
    step(8'h10, 0, 8'h10, 0, "rst_hold");
    rst_n = 1'b0;
    #1 check_idle_outputs("rst_async");
    #2 rst_n = 1'b1;
    // last restored to 7 means D0 beats D5.
    step(8'h21, 0, 8'h01, 0, "rst_after");
    step(8'h00, 0, 8'h00, 0, "rst_rel");
    step(8'h00, 0, 8'h00, 0, "rst_end");

    // Random phase with invariant checks.
    prev_gnt = gnt;
    hold = 0;
    for (int i = 0; i < 8; i++) starve[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7) == 0) req = 8'($urandom);
      done = ($urandom_range(15) == 0);
      prev_req = req;
      @(posedge clk);
      #1;
      chk("rnd_onehot", {7'd0, $onehot0(gnt)}, 8'h01);
      chk("rnd_xyz", {5'd0, x, y, z}, {5'd0, enc(gnt)});
      chk("rnd_vld", {7'd0, gnt_valid}, {7'd0, |gnt});
      if (gnt != 0) begin
        hold = (gnt == prev_gnt) ? hold + 1 : 1;
        chk("rnd_hold", {7'd0, hold <= MAX_HOLD}, 8'h01);
        if (prev_gnt == 0) begin
          int worst;
          worst = 0;
          for (int i = 0; i < 8; i++) begin
            if (!prev_req[i] || gnt[i]) starve[i] = 0;
            else starve[i]++;
            if (starve[i] > worst) worst = starve[i];
          end
          chk("rnd_starve", {7'd0, worst <= 7}, 8'h01);
        end
      end else begin
        hold = 0;
      end
      prev_gnt = gnt;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
